// File: rtl/alu_ctrl_mc_pkg.sv
// Shared encodings for the multi-cycle ALU control block: operation classes, funct codes,
// ALU control codes, MDU op codes, FSM states and the decoder result bundle.
package alu_ctrl_mc_pkg;

  localparam logic [2:0] AluOpAdd   = 3'd0;
  localparam logic [2:0] AluOpSub   = 3'd1;
  localparam logic [2:0] AluOpRtype = 3'd2;
  localparam logic [2:0] AluOpSlti  = 3'd3;
  localparam logic [2:0] AluOpAndi  = 3'd4;
  localparam logic [2:0] AluOpOri   = 3'd5;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  localparam logic [3:0] CtrlAnd     = 4'b0000;
  localparam logic [3:0] CtrlOr      = 4'b0001;
  localparam logic [3:0] CtrlAdd     = 4'b0010;
  localparam logic [3:0] CtrlSub     = 4'b0110;
  localparam logic [3:0] CtrlSlt     = 4'b0111;
  localparam logic [3:0] CtrlNor     = 4'b1100;
  localparam logic [3:0] CtrlIllegal = 4'b1111;

  localparam logic [1:0] MduMult  = 2'b00;
  localparam logic [1:0] MduMultu = 2'b01;
  localparam logic [1:0] MduDiv   = 2'b10;
  localparam logic [1:0] MduDivu  = 2'b11;

  localparam logic [1:0] SelAlu = 2'b00;
  localparam logic [1:0] SelHi  = 2'b01;
  localparam logic [1:0] SelLo  = 2'b10;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StBusy = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] hilo_sel;
    logic [1:0] mdu_op;
    logic       is_mdu;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational decode of operation class and funct field into ALU control, HI/LO select
// and MDU request. Unknown encodings fall to the illegal default so outputs never go X.
module alu_dec
  import alu_ctrl_mc_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{ctrl: CtrlIllegal, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0, illegal: 1'b1};
    case (alu_op)
      AluOpAdd:  dec = '{ctrl: CtrlAdd, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0,
                         illegal: 1'b0};
      AluOpSub:  dec = '{ctrl: CtrlSub, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0,
                         illegal: 1'b0};
      AluOpSlti: dec = '{ctrl: CtrlSlt, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0,
                         illegal: 1'b0};
      AluOpAndi: dec = '{ctrl: CtrlAnd, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0,
                         illegal: 1'b0};
      AluOpOri:  dec = '{ctrl: CtrlOr, hilo_sel: SelAlu, mdu_op: MduMult, is_mdu: 1'b0,
                         illegal: 1'b0};
      AluOpRtype: begin
        dec.illegal = 1'b0;
        case (funct)
          FnAdd:   dec.ctrl = CtrlAdd;
          FnSub:   dec.ctrl = CtrlSub;
          FnAnd:   dec.ctrl = CtrlAnd;
          FnOr:    dec.ctrl = CtrlOr;
          FnNor:   dec.ctrl = CtrlNor;
          FnSlt:   dec.ctrl = CtrlSlt;
          FnMfhi:  begin dec.ctrl = CtrlAdd; dec.hilo_sel = SelHi; end
          FnMflo:  begin dec.ctrl = CtrlAdd; dec.hilo_sel = SelLo; end
          FnMult:  begin dec.ctrl = CtrlAdd; dec.is_mdu = 1'b1; dec.mdu_op = MduMult;  end
          FnMultu: begin dec.ctrl = CtrlAdd; dec.is_mdu = 1'b1; dec.mdu_op = MduMultu; end
          FnDiv:   begin dec.ctrl = CtrlAdd; dec.is_mdu = 1'b1; dec.mdu_op = MduDiv;   end
          FnDivu:  begin dec.ctrl = CtrlAdd; dec.is_mdu = 1'b1; dec.mdu_op = MduDivu;  end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered ALU control with a multi-cycle MDU sequencer: stalls the pipeline while a
// multiply/divide runs and strobes the HI/LO write when it retires.
module alu_ctrl_mc
  import alu_ctrl_mc_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [1:0]        mdu_op_o,
  output logic              mdu_start_o,
  output logic              stall_o,
  output logic              hilo_we_o,
  output logic [1:0]        hilo_sel_o,
  output logic              illegal_o
);

  localparam logic [7:0] MulCnt = 8'(MUL_LAT - 1);
  localparam logic [7:0] DivCnt = 8'(DIV_LAT - 1);

  dec_t       dec;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ctrl_q;
  logic [1:0] sel_q, op_q;
  logic       ill_q, start_q;
  logic       accept, mdu_go;

  alu_dec u_alu_dec (
    .alu_op (ALUOp_i),
    .funct  (funct_i),
    .dec    (dec)
  );

  assign accept = (state_q == StIdle) && valid_i;
  assign mdu_go = accept && dec.is_mdu;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mdu_go) begin
          state_d = StBusy;
          cnt_d   = dec.mdu_op[1] ? DivCnt : MulCnt;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      ctrl_q  <= 4'b0000;
      sel_q   <= 2'b00;
      ill_q   <= 1'b0;
      op_q    <= 2'b00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= mdu_go;
      if (accept) begin
        ctrl_q <= dec.ctrl;
        sel_q  <= dec.hilo_sel;
        ill_q  <= dec.illegal;
      end
      if (mdu_go) op_q <= dec.mdu_op;
    end
  end

  assign ALUCtrl_o   = CTRL_W'(ctrl_q);
  assign hilo_sel_o  = sel_q;
  assign illegal_o   = ill_q;
  assign mdu_op_o    = op_q;
  assign mdu_start_o = start_q;
  assign hilo_we_o   = (state_q == StDone);
  // Gated by reset so the combinational stall path also reads 0 while reset is held.
  assign stall_o     = rst_i && (mdu_go || (state_q == StBusy));

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed scenarios plus randomized instruction mix
// checked against a table decoder and a latency-based timing model.
module tb_alu_ctrl_mc;

  localparam int MulLat = 4;
  localparam int DivLat = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] aluop = 3'd0;
  logic [5:0] funct = 6'd0;
  logic [3:0] ctrl;
  logic [1:0] mdu_op;
  logic       start;
  logic       stall;
  logic       we;
  logic [1:0] sel;
  logic       ill;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] exp_ctrl = 4'd0;
  logic [1:0] exp_sel  = 2'd0;
  logic       exp_ill  = 1'b0;
  logic [1:0] exp_op   = 2'd0;

  alu_ctrl_mc #(
    .CTRL_W  (4),
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .ALUOp_i     (aluop),
    .funct_i     (funct),
    .ALUCtrl_o   (ctrl),
    .mdu_op_o    (mdu_op),
    .mdu_start_o (start),
    .stall_o     (stall),
    .hilo_we_o   (we),
    .hilo_sel_o  (sel),
    .illegal_o   (ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics written as a plain lookup table.
  function automatic void ref_dec(input logic [2:0] op, input logic [5:0] f,
                                  output logic [3:0] c, output logic [1:0] s,
                                  output logic [1:0] m, output bit mdu, output bit il);
    c = 4'b1111; s = 2'd0; m = 2'd0; mdu = 1'b0; il = 1'b1;
    if (op == 3'd0) begin c = 4'b0010; il = 0; end
    if (op == 3'd1) begin c = 4'b0110; il = 0; end
    if (op == 3'd3) begin c = 4'b0111; il = 0; end
    if (op == 3'd4) begin c = 4'b0000; il = 0; end
    if (op == 3'd5) begin c = 4'b0001; il = 0; end
    if (op == 3'd2) begin
      il = 0;
      case (f)
        6'h20: c = 4'b0010;
        6'h22: c = 4'b0110;
        6'h24: c = 4'b0000;
        6'h25: c = 4'b0001;
        6'h27: c = 4'b1100;
        6'h2a: c = 4'b0111;
        6'h10: begin c = 4'b0010; s = 2'd1; end
        6'h12: begin c = 4'b0010; s = 2'd2; end
        6'h18, 6'h19, 6'h1a, 6'h1b: begin c = 4'b0010; mdu = 1; m = f[1:0]; end
        default: il = 1;
      endcase
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    valid = 1'($urandom);
    aluop = 3'($urandom);
    funct = 6'($urandom);
  endtask

  // MDU op accepted in cycle T: stall for LAT+1 cycles, start at T+1, HI/LO write at T+LAT+1.
  task automatic mdu_seq(input logic [5:0] f, input bit hold);
    logic [3:0] c; logic [1:0] s, m; bit mdu, il; int lat;
    ref_dec(3'd2, f, c, s, m, mdu, il);
    lat = m[1] ? DivLat : MulLat;
    valid = 1'b1; aluop = 3'd2; funct = f;
    #3;
    chk("stall_accept", stall, 1);
    chk("we_accept", we, 0);
    exp_ctrl = c; exp_sel = s; exp_ill = il; exp_op = m;
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      if (!hold) randomize_inputs();
      chk("start_busy", start, (k == 1) ? 1 : 0);
      chk("ctrl_busy", ctrl, exp_ctrl);
      chk("sel_busy", sel, exp_sel);
      chk("op_busy", mdu_op, exp_op);
      #3;
      chk("stall_busy", stall, 1);
      chk("we_busy", we, 0);
    end
    next_cycle();
    if (!hold) randomize_inputs();
    #3;
    chk("stall_done", stall, 0);
    chk("we_done", we, 1);
    chk("start_done", start, 0);
    next_cycle();
    valid = 1'b0;
    #3;
    chk("we_after", we, 0);
    chk("start_after", start, 0);
    chk("stall_after", stall, 0);
    chk("ctrl_after", ctrl, exp_ctrl);
    chk("ill_after", ill, exp_ill);
  endtask

  task automatic single(input logic [2:0] a, input logic [5:0] f, input bit v);
    logic [3:0] c; logic [1:0] s, m; bit mdu, il;
    ref_dec(a, f, c, s, m, mdu, il);
    if (v && mdu) begin
      mdu_seq(f, 1'b0);
      return;
    end
    valid = v; aluop = a; funct = f;
    #3;
    chk("stall_idle", stall, 0);
    chk("we_idle", we, 0);
    next_cycle();
    if (v) begin exp_ctrl = c; exp_sel = s; exp_ill = il; end
    chk("ctrl", ctrl, exp_ctrl);
    chk("sel", sel, exp_sel);
    chk("ill", ill, exp_ill);
    chk("start_idle", start, 0);
    valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, ctrl, 0);
    chk({tag, "_op"}, mdu_op, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_ill"}, ill, 0);
  endtask

  logic [5:0] legal_f [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a,
                               6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};

  initial begin
    #2;
    chk_all_zero("reset");
    next_cycle();
    rst = 1'b1;

    single(3'd2, 6'b100010, 1'b1);
    single(3'd4, 6'b000000, 1'b0);
    single(3'd2, 6'b100111, 1'b1);
    mdu_seq(6'b011000, 1'b0);
    mdu_seq(6'b011011, 1'b1);
    single(3'd6, 6'b100000, 1'b1);
    single(3'd0, 6'b000000, 1'b1);
    single(3'd2, 6'b111111, 1'b1);
    mdu_seq(6'b011010, 1'b0);
    single(3'd2, 6'b010010, 1'b1);
    single(3'd2, 6'b010000, 1'b1);

    // Reset two cycles into a multiply aborts it.
    valid = 1'b1; aluop = 3'd2; funct = 6'b011000;
    next_cycle();
    valid = 1'b0;
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("abort");
    next_cycle();
    next_cycle();
    chk_all_zero("held");
    rst = 1'b1;
    exp_ctrl = 4'd0; exp_sel = 2'd0; exp_ill = 1'b0; exp_op = 2'd0;
    single(3'd2, 6'b100010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #3;
      chk("we_post_reset", we, 0);
      chk("stall_post_reset", stall, 0);
      next_cycle();
    end

    for (int i = 0; i < 60; i++) begin
      logic [2:0] a;
      logic [5:0] f;
      int idx;
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = 3'd2;
      idx = $urandom_range(0, 13);
      f = (idx < 12) ? legal_f[idx] : 6'($urandom);
      single(a, f, ($urandom_range(0, 5) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
